// File: rtl/fm_sb_pkg.sv
// fm_sb_pkg -- shared definitions for the spy-buffer playback controller.
//   pb_mode_width : width of the pb_mode control port
//   pb_mode_e     : playback/spy mode encoding carried on pb_mode
//   state_t       : controller state type, with ST_* state constants
//   is_play_mode  : true for the two playback modes
package fm_sb_pkg;

  localparam int pb_mode_width = 2;

  typedef enum logic [pb_mode_width-1:0] {
    PB_SPY        = 2'd0,
    PB_SPY_FREEZE = 2'd1,
    PB_ONCE       = 2'd2,
    PB_LOOP       = 2'd3
  } pb_mode_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_SPY    = 2'd0;
  localparam state_t ST_POST   = 2'd1;
  localparam state_t ST_FROZEN = 2'd2;
  localparam state_t ST_PLAY   = 2'd3;

  function automatic logic is_play_mode(input pb_mode_e m);
    return (m == PB_ONCE) || (m == PB_LOOP);
  endfunction

endpackage

// File: rtl/fm_sb_rd_pipe.sv
// fm_sb_rd_pipe -- read-valid delay line for the spy-buffer controller.
// Delays the read strobe by exactly RD_LAT cycles so that the valid flag
// lines up with data at the memory output. Cleared by reset so no stale
// valid pulse can appear after reset is released.
//   clk   in  : clock, rising edge
//   rst_n in  : asynchronous active-low reset
//   vld_i in  : read strobe issued this cycle
//   vld_o out : read strobe delayed by RD_LAT cycles (RD_LAT in 1..4)
module fm_sb_rd_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_i,
  output logic vld_o
);

  logic [RD_LAT-1:0] pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= vld_i;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign vld_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/fm_sb_pb_ctrl.sv
// fm_sb_pb_ctrl -- spy-buffer capture / freeze / playback controller.
// One instance controls one spy buffer; a system with several buffers
// generates one instance per buffer.
//   clk, rst_n              : clock, asynchronous active-low reset
//   pb_mode                 : 0 spy, 1 spy-then-freeze, 2 play once, 3 play loop
//   spy_vld                 : monitored word valid (captured in SPY/POST)
//   freeze_req, post_trig   : freeze trigger and words still captured after it
//   pb_start, pb_base,
//   pb_len, pb_en           : playback start, base address, length (0 = full
//                             depth), and per-cycle read throttle
//   mem_wr_en, mem_wr_addr  : buffer write strobe / address
//   mem_rd_en, mem_rd_addr  : buffer read strobe / address
//   pb_vld                  : read data valid, RD_LAT cycles after mem_rd_en
//   frozen, wrapped, busy   : FROZEN state; write pointer wrapped; POST or PLAY
//   trig_addr, wr_ptr       : write pointer latched at freeze; live write pointer
module fm_sb_pb_ctrl
  import fm_sb_pkg::*;
#(
  parameter int SB_AW  = 10,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [pb_mode_width-1:0] pb_mode,
  input  logic                     spy_vld,
  input  logic                     freeze_req,
  input  logic [SB_AW-1:0]         post_trig,
  input  logic                     pb_start,
  input  logic [SB_AW-1:0]         pb_base,
  input  logic [SB_AW-1:0]         pb_len,
  input  logic                     pb_en,
  output logic                     mem_wr_en,
  output logic [SB_AW-1:0]         mem_wr_addr,
  output logic                     mem_rd_en,
  output logic [SB_AW-1:0]         mem_rd_addr,
  output logic                     pb_vld,
  output logic                     frozen,
  output logic                     wrapped,
  output logic                     busy,
  output logic [SB_AW-1:0]         trig_addr,
  output logic [SB_AW-1:0]         wr_ptr
);

  localparam logic [SB_AW-1:0] LAST_ADDR = '1;
  localparam logic [SB_AW-1:0] ONE       = SB_AW'(1);

  state_t           state_q, state_d;
  logic [SB_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SB_AW-1:0] trig_addr_q, trig_addr_d;
  logic [SB_AW-1:0] post_cnt_q, post_cnt_d;
  logic [SB_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SB_AW-1:0] rd_cnt_q, rd_cnt_d;
  logic             wrapped_q, wrapped_d;

  pb_mode_e mode;
  logic     play_mode;
  logic     capturing;
  logic     wr_fire;
  logic     rd_fire;

  assign mode      = pb_mode_e'(pb_mode);
  assign play_mode = is_play_mode(mode);
  assign capturing = (state_q == ST_SPY) || (state_q == ST_POST);

  // Strobes are gated by rst_n so nothing is issued while reset is held;
  // the first write lands on the first edge after deassertion.
  assign wr_fire = rst_n && capturing && spy_vld;
  assign rd_fire = rst_n && (state_q == ST_PLAY) && play_mode && pb_en;

  // Next-state logic. rd_cnt counts down and the read taken at rd_cnt == 1 is
  // the last one, so a loaded length of 0 naturally yields full-depth reads.
  // A write in the trigger cycle is the first of the post_trig words, so it
  // both sets trig_addr and consumes one count.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    post_cnt_d  = post_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    wrapped_d   = wrapped_q;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ONE;
      if (wr_ptr_q == LAST_ADDR) begin
        wrapped_d = 1'b1;
      end
    end

    case (state_q)
      ST_SPY: begin
        if ((mode == PB_SPY_FREEZE) && freeze_req) begin
          trig_addr_d = wr_ptr_q;
          if ((post_trig == '0) || ((post_trig == ONE) && spy_vld)) begin
            state_d = ST_FROZEN;
          end else begin
            state_d    = ST_POST;
            post_cnt_d = post_trig - SB_AW'(spy_vld);
          end
        end
      end

      ST_POST: begin
        if (wr_fire) begin
          post_cnt_d = post_cnt_q - ONE;
          if (post_cnt_q == ONE) begin
            state_d = ST_FROZEN;
          end
        end
      end

      ST_FROZEN: begin
        if (!play_mode) begin
          state_d   = ST_SPY;
          wrapped_d = 1'b0;
        end else if (pb_start) begin
          rd_ptr_d = pb_base;
          rd_cnt_d = pb_len;
          state_d  = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (!play_mode) begin
          state_d = ST_SPY;
        end else if (pb_en) begin
          if (rd_cnt_q == ONE) begin
            if (mode == PB_ONCE) begin
              state_d  = ST_FROZEN;
              rd_ptr_d = rd_ptr_q + ONE;
              rd_cnt_d = '0;
            end else begin
              rd_ptr_d = pb_base;
              rd_cnt_d = pb_len;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + ONE;
            rd_cnt_d = rd_cnt_q - ONE;
          end
        end
      end

      default: begin
        state_d = ST_SPY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SPY;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      wrapped_q   <= wrapped_d;
    end
  end

  fm_sb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (rd_fire),
    .vld_o (pb_vld)
  );

  assign mem_wr_en   = wr_fire;
  assign mem_wr_addr = wr_ptr_q;
  assign mem_rd_en   = rd_fire;
  assign mem_rd_addr = rd_ptr_q;
  assign frozen      = (state_q == ST_FROZEN);
  assign busy        = (state_q == ST_POST) || (state_q == ST_PLAY);
  assign wrapped     = wrapped_q;
  assign trig_addr   = trig_addr_q;
  assign wr_ptr      = wr_ptr_q;

endmodule

// File: tb/tb_fm_sb_pb_ctrl.sv
// tb_fm_sb_pb_ctrl -- scoreboard bench for fm_sb_pb_ctrl (SB_AW=10, RD_LAT=2).
// Stimulus pushes expected write/read addresses into queues; a negedge monitor
// pops and compares on every mem_wr_en / mem_rd_en and checks pb_vld timing.
module tb_fm_sb_pb_ctrl;

  localparam int SB_AW  = 10;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << SB_AW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       pb_mode;
  logic             spy_vld;
  logic             freeze_req;
  logic [SB_AW-1:0] post_trig;
  logic             pb_start;
  logic [SB_AW-1:0] pb_base;
  logic [SB_AW-1:0] pb_len;
  logic             pb_en;
  logic             mem_wr_en;
  logic [SB_AW-1:0] mem_wr_addr;
  logic             mem_rd_en;
  logic [SB_AW-1:0] mem_rd_addr;
  logic             pb_vld;
  logic             frozen;
  logic             wrapped;
  logic             busy;
  logic [SB_AW-1:0] trig_addr;
  logic [SB_AW-1:0] wr_ptr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int expWr[$];
  int expRd[$];
  int expVld[$];

  fm_sb_pb_ctrl #(
    .SB_AW  (SB_AW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_mode     (pb_mode),
    .spy_vld     (spy_vld),
    .freeze_req  (freeze_req),
    .post_trig   (post_trig),
    .pb_start    (pb_start),
    .pb_base     (pb_base),
    .pb_len      (pb_len),
    .pb_en       (pb_en),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .pb_vld      (pb_vld),
    .frozen      (frozen),
    .wrapped     (wrapped),
    .busy        (busy),
    .trig_addr   (trig_addr),
    .wr_ptr      (wr_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: validates every strobe the DUT presents against the queues.
  always @(negedge clk) begin
    bit vldDue;
    int expAddr;
    vldDue = (expVld.size() > 0) && (expVld[0] == cyc);
    if (vldDue) void'(expVld.pop_front());
    if (vldDue || (pb_vld !== 1'b0)) begin
      checks++;
      if (pb_vld !== vldDue) begin
        errors++;
        $display("[TB] FAIL pb_vld_timing cyc=%0d got %b expected %b", cyc, pb_vld, vldDue);
      end
    end
    if (mem_rd_en !== 1'b0) begin
      checks++;
      if (expRd.size() == 0) begin
        errors++;
        $display("[TB] FAIL rd_unexpected cyc=%0d got addr %0d expected no read", cyc, mem_rd_addr);
      end else begin
        expAddr = expRd.pop_front();
        if (mem_rd_addr !== SB_AW'(expAddr)) begin
          errors++;
          $display("[TB] FAIL rd_addr cyc=%0d got %0d expected %0d", cyc, mem_rd_addr, expAddr);
        end
      end
      expVld.push_back(cyc + RD_LAT);
    end
    if (mem_wr_en !== 1'b0) begin
      checks++;
      if (expWr.size() == 0) begin
        errors++;
        $display("[TB] FAIL wr_unexpected cyc=%0d got addr %0d expected no write", cyc, mem_wr_addr);
      end else begin
        expAddr = expWr.pop_front();
        if (mem_wr_addr !== SB_AW'(expAddr)) begin
          errors++;
          $display("[TB] FAIL wr_addr cyc=%0d got %0d expected %0d", cyc, mem_wr_addr, expAddr);
        end
      end
    end
  end

  function automatic void pushWr(input int start, input int n);
    for (int i = 0; i < n; i++) expWr.push_back((start + i) % DEPTH);
  endfunction

  function automatic void pushRd(input int start, input int n);
    for (int i = 0; i < n; i++) expRd.push_back((start + i) % DEPTH);
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; pb_mode = 2'd0; spy_vld = 1'b0; freeze_req = 1'b0;
    post_trig = '0; pb_start = 1'b0; pb_base = '0; pb_len = '0; pb_en = 1'b0;
    applyStimulus(3);
    spy_vld = 1'b1;
    #1;
    checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 0);
    checkOutput("rst_wr_ptr", 32'(wr_ptr), 0);
    checkOutput("rst_frozen", 32'(frozen), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_wrapped", 32'(wrapped), 0);
    checkOutput("rst_trig_addr", 32'(trig_addr), 0);
    checkOutput("rst_pb_vld", 32'(pb_vld), 0);
    checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 0);
    applyStimulus(1);

    // Spy mode: 1030 writes wrap the pointer; freeze/start pulses ignored.
    rst_n = 1'b1;
    pushWr(0, 1030);
    applyStimulus(500);
    freeze_req = 1'b1; pb_start = 1'b1;
    applyStimulus(1);
    freeze_req = 1'b0; pb_start = 1'b0;
    applyStimulus(522);
    checkOutput("a_wrapped_before_1023", 32'(wrapped), 0);
    applyStimulus(7);
    checkOutput("a_wr_ptr", 32'(wr_ptr), 6);
    checkOutput("a_wrapped", 32'(wrapped), 1);
    checkOutput("a_frozen", 32'(frozen), 0);
    checkOutput("a_busy", 32'(busy), 0);

    // Spy-then-freeze at pointer 100 with 5 post-trigger words.
    pushWr(6, 99);
    applyStimulus(94);
    checkOutput("b_wr_ptr_pre", 32'(wr_ptr), 100);
    pb_mode = 2'd1; freeze_req = 1'b1; post_trig = 10'd5;
    applyStimulus(1);
    freeze_req = 1'b0; pb_mode = 2'd2;
    checkOutput("b_busy_post", 32'(busy), 1);
    checkOutput("b_trig_addr", 32'(trig_addr), 100);
    freeze_req = 1'b1; post_trig = 10'd9;
    applyStimulus(1);
    freeze_req = 1'b0;
    applyStimulus(2);
    checkOutput("b_frozen_early", 32'(frozen), 0);
    applyStimulus(1);
    checkOutput("b_frozen", 32'(frozen), 1);
    checkOutput("b_wr_ptr", 32'(wr_ptr), 105);
    checkOutput("b_trig_addr_hold", 32'(trig_addr), 100);
    applyStimulus(1);
    spy_vld = 1'b0;
    checkOutput("b_wr_ptr_hold", 32'(wr_ptr), 105);

    // Playback once across the top of the buffer; freeze_req alongside start.
    pb_base = 10'd1020; pb_len = 10'd8; pb_start = 1'b1; freeze_req = 1'b1; pb_en = 1'b1;
    pushRd(1020, 8);
    applyStimulus(1);
    pb_start = 1'b0; freeze_req = 1'b0;
    checkOutput("c_busy", 32'(busy), 1);
    applyStimulus(8);
    checkOutput("c_frozen_end", 32'(frozen), 1);
    checkOutput("c_trig_addr", 32'(trig_addr), 100);
    applyStimulus(4);

    // Leave FROZEN for SPY (clears wrapped), ignore pb_start in SPY,
    // then freeze immediately with post_trig 0.
    pb_mode = 2'd1;
    applyStimulus(1);
    checkOutput("c2_wrapped_clr", 32'(wrapped), 0);
    checkOutput("c2_frozen", 32'(frozen), 0);
    pb_start = 1'b1;
    applyStimulus(1);
    pb_start = 1'b0;
    checkOutput("c2_start_ignored", 32'(busy), 0);
    freeze_req = 1'b1; post_trig = 10'd0;
    applyStimulus(1);
    freeze_req = 1'b0; pb_mode = 2'd3;
    checkOutput("c2_frozen_direct", 32'(frozen), 1);
    checkOutput("c2_trig_addr", 32'(trig_addr), 105);

    // Loop playback, length 3, throttled then continuous.
    pb_base = 10'd10; pb_len = 10'd3; pb_start = 1'b1;
    for (int i = 0; i < 13; i++) expRd.push_back(10 + (i % 3));
    applyStimulus(1);
    pb_start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      pb_en = (k % 2 == 0);
      applyStimulus(1);
    end
    pb_en = 1'b1;
    applyStimulus(6);

    // Abort playback into spy mode; in-flight valids still appear.
    pb_mode = 2'd0; spy_vld = 1'b1;
    pushWr(105, 3);
    applyStimulus(1);
    checkOutput("e_busy", 32'(busy), 0);
    checkOutput("e_frozen", 32'(frozen), 0);
    applyStimulus(3);
    spy_vld = 1'b0;
    checkOutput("e_wr_ptr", 32'(wr_ptr), 108);
    checkOutput("e_wrapped", 32'(wrapped), 0);

    // Reset for one cycle in the middle of POST.
    pb_mode = 2'd1; post_trig = 10'd20; freeze_req = 1'b1; spy_vld = 1'b1;
    pushWr(108, 4);
    applyStimulus(1);
    freeze_req = 1'b0;
    applyStimulus(3);
    checkOutput("f_busy_post", 32'(busy), 1);
    checkOutput("f_trig_addr", 32'(trig_addr), 108);
    rst_n = 1'b0;
    #1;
    checkOutput("f_rst_busy", 32'(busy), 0);
    checkOutput("f_rst_wr_ptr", 32'(wr_ptr), 0);
    checkOutput("f_rst_trig", 32'(trig_addr), 0);
    checkOutput("f_rst_wr_en", 32'(mem_wr_en), 0);
    applyStimulus(1);
    rst_n = 1'b1;
    pushWr(0, 25);
    applyStimulus(25);
    spy_vld = 1'b0;
    checkOutput("f_frozen", 32'(frozen), 0);
    checkOutput("f_busy", 32'(busy), 0);
    checkOutput("f_wr_ptr", 32'(wr_ptr), 25);

    // Full-depth playback (pb_len 0), then reset mid-PLAY.
    freeze_req = 1'b1; post_trig = 10'd0;
    applyStimulus(1);
    freeze_req = 1'b0; pb_mode = 2'd2;
    checkOutput("g_frozen", 32'(frozen), 1);
    checkOutput("g_trig_addr", 32'(trig_addr), 25);
    pb_base = 10'd1000; pb_len = 10'd0; pb_start = 1'b1; pb_en = 1'b1;
    pushRd(1000, DEPTH);
    applyStimulus(1);
    pb_start = 1'b0;
    applyStimulus(DEPTH - 1);
    checkOutput("g_busy_last", 32'(busy), 1);
    applyStimulus(1);
    checkOutput("g_frozen_end", 32'(frozen), 1);
    applyStimulus(4);
    pb_base = 10'd5; pb_len = 10'd10; pb_start = 1'b1;
    pushRd(5, 3);
    applyStimulus(1);
    pb_start = 1'b0;
    applyStimulus(3);
    rst_n = 1'b0;
    expVld.delete();
    #1;
    checkOutput("g_rst_pb_vld", 32'(pb_vld), 0);
    checkOutput("g_rst_rd_en", 32'(mem_rd_en), 0);
    checkOutput("g_rst_busy", 32'(busy), 0);
    applyStimulus(1);
    rst_n = 1'b1;
    applyStimulus(6);
    checkOutput("g_frozen_after", 32'(frozen), 0);
    checkOutput("g_wr_ptr_after", 32'(wr_ptr), 0);

    checkOutput("end_wr_queue", 32'(expWr.size()), 0);
    checkOutput("end_rd_queue", 32'(expRd.size()), 0);
    checkOutput("end_vld_queue", 32'(expVld.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
